// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format encodings, instruction field bit
// positions (common with the instruction register) and the packer FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        FMT_R    = 2'b00,
        FMT_I    = 2'b01,
        FMT_J    = 2'b10,
        FMT_RSVD = 2'b11
    } fmt_e;

    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RA_LSB    = 21;
    localparam int unsigned RB_LSB    = 16;
    localparam int unsigned WR2_LSB   = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

endpackage

// File: rtl/inst_packer_if.sv
// Field handshake and instruction-memory write bus of the packer.
// INST_PACKER_VERIFY_EN adds the read-back signals mem_re / mem_rdata.
interface inst_packer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [4:0]        wr2;
    logic [4:0]        shift_amt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       address;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
`ifdef INST_PACKER_VERIFY_EN
    logic              mem_re;
    logic [31:0]       mem_rdata;
`endif

    modport slave (
        input  in_valid, fmt, opcode, ra, rb, wr2, shift_amt, funct, imm, address,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ack
`ifdef INST_PACKER_VERIFY_EN
        ,
        output mem_re,
        input  mem_rdata
`endif
    );

    modport master (
        output in_valid, fmt, opcode, ra, rb, wr2, shift_amt, funct, imm, address,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ack
`ifdef INST_PACKER_VERIFY_EN
        ,
        input  mem_re,
        output mem_rdata
`endif
    );

endinterface

// File: rtl/inst_encode.sv
// Combinational packer: decoded fields + format -> 32-bit MIPS-style word.
// legal_o is low for the reserved format, in which case the word is zero.
module inst_encode
    import cpu_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic [4:0]  wr2_i,
    input  logic [4:0]  shift_amt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] address_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        word_o[OPC_LSB +: 6] = opcode_i;
        case (fmt_e'(fmt_i))
            FMT_R: begin
                word_o[RA_LSB +: 5]    = ra_i;
                word_o[RB_LSB +: 5]    = rb_i;
                word_o[WR2_LSB +: 5]   = wr2_i;
                word_o[SHAMT_LSB +: 5] = shift_amt_i;
                word_o[FUNCT_LSB +: 6] = funct_i;
            end
            FMT_I: begin
                word_o[RA_LSB +: 5]   = ra_i;
                word_o[RB_LSB +: 5]   = rb_i;
                word_o[IMM_LSB +: 16] = imm_i;
            end
            FMT_J: begin
                word_o[ADDR_LSB +: 26] = address_i;
            end
            FMT_RSVD: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_packer.sv
// Instruction packer/loader: packs field tuples and writes them to sequential
// instruction-memory addresses. INST_PACKER_VERIFY_EN adds a read-back check.
module inst_packer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    inst_packer_if.slave    bus,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err
`ifdef INST_PACKER_VERIFY_EN
    ,
    output logic            verify_err
`endif
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, err_q, clr_pend_q;
    logic [31:0]       word;
    logic              legal, accept, do_clr;
`ifdef INST_PACKER_VERIFY_EN
    logic              re_q, verr_q;
`endif

    inst_encode u_enc (
        .fmt_i       (bus.fmt),
        .opcode_i    (bus.opcode),
        .ra_i        (bus.ra),
        .rb_i        (bus.rb),
        .wr2_i       (bus.wr2),
        .shift_amt_i (bus.shift_amt),
        .funct_i     (bus.funct),
        .imm_i       (bus.imm),
        .address_i   (bus.address),
        .word_o      (word),
        .legal_o     (legal)
    );

    assign ptr_d   = ptr_q + PTR_ONE;
    assign count_d = count_q[ADDR_W] ? count_q : count_q + CNT_ONE;
    // A clr seen outside IDLE is remembered and applied once IDLE is reached.
    assign do_clr  = clr || clr_pend_q;

    assign bus.in_ready  = rst_n && (state_q == ST_IDLE) && !full_q && !do_clr;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign full          = full_q;
    assign err           = err_q;
`ifdef INST_PACKER_VERIFY_EN
    assign bus.mem_re    = re_q;
    assign verify_err    = verr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= BASE;
            mem_addr_q <= BASE;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
`ifdef INST_PACKER_VERIFY_EN
            re_q       <= 1'b0;
            verr_q     <= 1'b0;
`endif
        end else begin
            if (state_q != ST_IDLE && clr) clr_pend_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    clr_pend_q <= 1'b0;
                    if (do_clr) begin
                        ptr_q      <= BASE;
                        mem_addr_q <= BASE;
                        count_q    <= '0;
                        full_q     <= 1'b0;
                        err_q      <= 1'b0;
`ifdef INST_PACKER_VERIFY_EN
                        verr_q     <= 1'b0;
`endif
                    end else if (accept) begin
                        if (legal) begin
                            wdata_q    <= word;
                            mem_addr_q <= ptr_q;
                            we_q       <= 1'b1;
                            state_q    <= ST_WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        we_q    <= 1'b0;
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        if (mem_addr_q == LAST) full_q <= 1'b1;
`ifdef INST_PACKER_VERIFY_EN
                        re_q    <= 1'b1;
                        state_q <= ST_VERIFY;
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef INST_PACKER_VERIFY_EN
                ST_VERIFY: begin
                    re_q    <= 1'b0;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (bus.mem_rdata != wdata_q) verr_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_packer.sv
// Directed bench for inst_packer: an ADDR_W=8 instance for packing, stalls,
// reserved format, clr and reset; an ADDR_W=2 instance for full/wrap.
module tb_inst_packer;
    import cpu_pkg::*;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wr2;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] adr;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr8, clr2, ack8, v8, v2;
    logic [1:0]  f_fmt;
    logic [5:0]  f_op, f_fn;
    logic [4:0]  f_ra, f_rb, f_wr2, f_sh;
    logic [15:0] f_imm;
    logic [25:0] f_adr;
    logic [8:0]  count8;
    logic [2:0]  count2;
    logic        full8, err8, full2, err2;
    int          n_checks = 0;
    int          n_err = 0;
    vec_t        vt [0:6];
    vec_t        vr;

    inst_packer_if #(.ADDR_W(8)) bus8 ();
    inst_packer_if #(.ADDR_W(2)) bus2 ();

    assign bus8.in_valid = v8;     assign bus2.in_valid = v2;
    assign bus8.fmt = f_fmt;       assign bus2.fmt = f_fmt;
    assign bus8.opcode = f_op;     assign bus2.opcode = f_op;
    assign bus8.ra = f_ra;         assign bus2.ra = f_ra;
    assign bus8.rb = f_rb;         assign bus2.rb = f_rb;
    assign bus8.wr2 = f_wr2;       assign bus2.wr2 = f_wr2;
    assign bus8.shift_amt = f_sh;  assign bus2.shift_amt = f_sh;
    assign bus8.funct = f_fn;      assign bus2.funct = f_fn;
    assign bus8.imm = f_imm;       assign bus2.imm = f_imm;
    assign bus8.address = f_adr;   assign bus2.address = f_adr;
    assign bus8.mem_ack = ack8;    assign bus2.mem_ack = 1'b1;

`ifdef INST_PACKER_VERIFY_EN
    logic        verr8, verr2, corrupt;
    logic [31:0] mem8 [0:255];
    always @(posedge clk) begin
        if (bus8.mem_we && bus8.mem_ack) mem8[bus8.mem_addr] <= bus8.mem_wdata;
        if (bus8.mem_re) bus8.mem_rdata <= mem8[bus8.mem_addr] ^ {31'b0, corrupt};
    end
    assign bus2.mem_rdata = bus2.mem_wdata;
`endif

    inst_packer #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .bus(bus8.slave),
        .count(count8), .full(full8), .err(err8)
`ifdef INST_PACKER_VERIFY_EN
        , .verify_err(verr8)
`endif
    );

    inst_packer #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .bus(bus2.slave),
        .count(count2), .full(full2), .err(err2)
`ifdef INST_PACKER_VERIFY_EN
        , .verify_err(verr2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input vec_t v, input bit to2);
        int t = 0;
        f_fmt = v.fmt; f_op = v.op; f_ra = v.ra; f_rb = v.rb; f_wr2 = v.wr2;
        f_sh = v.sh; f_fn = v.fn; f_imm = v.imm; f_adr = v.adr;
        if (to2) v2 = 1'b1; else v8 = 1'b1;
        while (!(to2 ? bus2.in_ready : bus8.in_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(t < 20), 32'd1);
        @(negedge clk);
        v8 = 1'b0;
        v2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            fmt    op     ra     rb     wr2    sh     fn     imm       adr           exp
        vt[0] = '{2'b00, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 32'h00221820};
        vt[1] = '{2'b01, 6'h23, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0000000, 32'h8C220004};
        vt[2] = '{2'b10, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010};
        vt[3] = '{2'b00, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h2AAAAAA, 32'h03FFFFFF};
        vt[4] = '{2'b01, 6'h3F, 5'd0,  5'd31, 5'd31, 5'd7,  6'h3F, 16'h8000, 26'h3FFFFFF, 32'hFC1F8000};
        vt[5] = '{2'b10, 6'h03, 5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'h1234, 26'h3FFFFFF, 32'h0FFFFFFF};
        vt[6] = '{2'b00, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd16, 6'h01, 16'h0000, 26'h0000000, 32'hFC000401};

        rst_n = 1'b0; clr8 = 1'b0; clr2 = 1'b0; ack8 = 1'b1; v8 = 1'b0; v2 = 1'b0;
        f_fmt = '0; f_op = '0; f_ra = '0; f_rb = '0; f_wr2 = '0; f_sh = '0;
        f_fn = '0; f_imm = '0; f_adr = '0;
`ifdef INST_PACKER_VERIFY_EN
        corrupt = 1'b0;
`endif
        #3;
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus8.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus8.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus8.mem_wdata, 32'd0);
        chk("rst_count", 32'(count8), 32'd0);
        chk("rst_full", 32'(full8), 32'd0);
        chk("rst_err", 32'(err8), 32'd0);
        chk("rst2_in_ready", 32'(bus2.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single writes, memory acks immediately
        for (int i = 0; i < 7; i++) begin
            send(vt[i], 1'b0);
            chk("tbl_we", 32'(bus8.mem_we), 32'd1);
            chk("tbl_addr", 32'(bus8.mem_addr), 32'(i));
            chk("tbl_wdata", bus8.mem_wdata, vt[i].exp);
            chk("tbl_ready_low", 32'(bus8.in_ready), 32'd0);
            @(negedge clk);
            chk("tbl_we_done", 32'(bus8.mem_we), 32'd0);
            chk("tbl_count", 32'(count8), 32'(i + 1));
        end

        // Ack delayed 3 cycles: write held for 4 cycles, count steps once
        ack8 = 1'b0;
        send(vt[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_we", 32'(bus8.mem_we), 32'd1);
            chk("stall_addr", 32'(bus8.mem_addr), 32'd7);
            chk("stall_wdata", bus8.mem_wdata, vt[1].exp);
            chk("stall_count", 32'(count8), 32'd7);
            if (k < 3) @(negedge clk);
        end
        ack8 = 1'b1;
        @(negedge clk);
        chk("stall_we_done", 32'(bus8.mem_we), 32'd0);
        chk("stall_count_done", 32'(count8), 32'd8);

        // Reserved format: handshake, no write, sticky err; clr clears
        vr = vt[0];
        vr.fmt = 2'b11;
        send(vr, 1'b0);
        chk("rsvd_err", 32'(err8), 32'd1);
        chk("rsvd_we", 32'(bus8.mem_we), 32'd0);
        chk("rsvd_count", 32'(count8), 32'd8);
        @(negedge clk);
        chk("rsvd_we_later", 32'(bus8.mem_we), 32'd0);
        chk("rsvd_ready", 32'(bus8.in_ready), 32'd1);
        chk("rsvd_err_sticky", 32'(err8), 32'd1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("clr_err", 32'(err8), 32'd0);
        chk("clr_count", 32'(count8), 32'd0);
        chk("clr_addr", 32'(bus8.mem_addr), 32'd0);
        @(negedge clk);
        send(vt[2], 1'b0);
        chk("clr_next_addr", 32'(bus8.mem_addr), 32'd0);
        chk("clr_next_wdata", bus8.mem_wdata, vt[2].exp);
        @(negedge clk);
        chk("clr_next_count", 32'(count8), 32'd1);

        // clr raised during WRITE is applied only after returning to IDLE
        ack8 = 1'b0;
        send(vt[3], 1'b0);
        chk("pend_addr", 32'(bus8.mem_addr), 32'd1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("pend_we_held", 32'(bus8.mem_we), 32'd1);
        ack8 = 1'b1;
        @(negedge clk);
        chk("pend_count_ack", 32'(count8), 32'd2);
        for (int t = 0; t < 10 && !bus8.in_ready; t++) @(negedge clk);
        chk("pend_ready", 32'(bus8.in_ready), 32'd1);
        chk("pend_count_clr", 32'(count8), 32'd0);

        // Asynchronous reset in the middle of a write
        ack8 = 1'b0;
        send(vt[4], 1'b0);
        chk("arst_we_before", 32'(bus8.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we_async", 32'(bus8.mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack8 = 1'b1;
        chk("arst_count", 32'(count8), 32'd0);
        chk("arst_addr", 32'(bus8.mem_addr), 32'd0);
        @(negedge clk);
        chk("arst_ready", 32'(bus8.in_ready), 32'd1);

`ifdef INST_PACKER_VERIFY_EN
        send(vt[5], 1'b0);
        for (int t = 0; t < 10 && !bus8.in_ready; t++) @(negedge clk);
        chk("verify_ok", 32'(verr8), 32'd0);
        corrupt = 1'b1;
        send(vt[6], 1'b0);
        for (int t = 0; t < 10 && !bus8.in_ready; t++) @(negedge clk);
        corrupt = 1'b0;
        chk("verify_err_set", 32'(verr8), 32'd1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("verify_err_clr", 32'(verr8), 32'd0);
        @(negedge clk);
`endif

        // ADDR_W=2: four words fill the memory, then accepts stop until clr
        for (int i = 0; i < 4; i++) begin
            send(vt[i], 1'b1);
            chk("w2_addr", 32'(bus2.mem_addr), 32'(i));
            @(negedge clk);
        end
        chk("w2_full", 32'(full2), 32'd1);
        chk("w2_count", 32'(count2), 32'd4);
        chk("w2_ready", 32'(bus2.in_ready), 32'd0);
        chk("w2_last_wdata", bus2.mem_wdata, vt[3].exp);
        v2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w2_no_write", 32'(bus2.mem_we), 32'd0);
        end
        v2 = 1'b0;
        chk("w2_count_hold", 32'(count2), 32'd4);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        chk("w2_clr_full", 32'(full2), 32'd0);
        chk("w2_clr_count", 32'(count2), 32'd0);
        @(negedge clk);
        chk("w2_clr_ready", 32'(bus2.in_ready), 32'd1);
        send(vt[6], 1'b1);
        chk("w2_wrap_addr", 32'(bus2.mem_addr), 32'd0);
        chk("w2_wrap_wdata", bus2.mem_wdata, vt[6].exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
